// File: rtl/serial_mag_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
//   state_e : FSM encoding (IDLE, CMP, DONE)
//   SLICE_W : bits of each operand examined per compare cycle
package serial_mag_cmp_pkg;

  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_mag_cmp_cmp2_slice.sv
// cmp2_slice: combinational compare of one 2-bit slice pair.
// Ports:
//   x, y : slices of operand A and operand B
//   eq   : x == y
//   gt   : x >  y (unsigned)
module cmp2_slice
  import serial_mag_cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic               eq,
  output logic               gt
);

  // Equality as a product of per-bit "both high or both low" terms.
  assign eq = ((x[1] & y[1]) | (~x[1] & ~y[1])) &
              ((x[0] & y[0]) | (~x[0] & ~y[0]));

  // Upper bit decides unless it ties, then the lower bit decides.
  assign gt = (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);

endmodule

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: multi-cycle unsigned magnitude comparator, MSB slice first,
// two bits per cycle.
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   start            : compare request, only honoured in IDLE
//   a, b             : W-bit operands, captured on the accepting edge
//   busy             : high in CMP and DONE
//   done             : one-cycle pulse, result flags valid
//   aeqb, agtb, altb : one-hot result, held until next accepted start
// Build option: SERIAL_MAG_CMP_CONST_TIME_EN removes the early exit so every
// compare takes W/2 cycles regardless of operand values.
module serial_mag_cmp #(
  parameter  int unsigned W  = 8,
  localparam int unsigned CW = $clog2(W/2 + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb
);
  import serial_mag_cmp_pkg::*;

  generate
    if (W < 2 || (W % 2) != 0) begin : g_bad_w
      $error("serial_mag_cmp: W must be even and >= 2");
    end
  endgenerate

  state_e         state_q, state_d;
  logic [W-1:0]   sa_q, sa_d;
  logic [W-1:0]   sb_q, sb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           aeqb_q, aeqb_d;
  logic           agtb_q, agtb_d;
  logic           altb_q, altb_d;
  logic           sl_eq, sl_gt;
`ifdef SERIAL_MAG_CMP_CONST_TIME_EN
  logic           dec_q, dec_d;
`endif

  // Top slice of the registered operands is the only thing compared each cycle.
  cmp2_slice u_slice (
    .x  (sa_q[W-1 -: SLICE_W]),
    .y  (sb_q[W-1 -: SLICE_W]),
    .eq (sl_eq),
    .gt (sl_gt)
  );

  // Next-state, datapath and result-flag logic.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;
`ifdef SERIAL_MAG_CMP_CONST_TIME_EN
    dec_d   = dec_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(W/2);
          aeqb_d  = 1'b0;
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
`ifdef SERIAL_MAG_CMP_CONST_TIME_EN
          dec_d   = 1'b0;
`endif
          state_d = CMP;
        end
      end
      CMP: begin
`ifdef SERIAL_MAG_CMP_CONST_TIME_EN
        // First differing slice latches the verdict; later slices are ignored.
        if (!dec_q && !sl_eq) begin
          dec_d  = 1'b1;
          agtb_d = sl_gt;
          altb_d = ~sl_gt;
        end
        if (cnt_q == CW'(1)) begin
          aeqb_d  = ~dec_q & sl_eq;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << SLICE_W;
          sb_d  = sb_q << SLICE_W;
          cnt_d = cnt_q - CW'(1);
        end
`else
        if (!sl_eq) begin
          agtb_d  = sl_gt;
          altb_d  = ~sl_gt;
          state_d = DONE;
        end else if (cnt_q == CW'(1)) begin
          aeqb_d  = 1'b1;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << SLICE_W;
          sb_d  = sb_q << SLICE_W;
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Moore status flags registered from the next state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
`ifdef SERIAL_MAG_CMP_CONST_TIME_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
`ifdef SERIAL_MAG_CMP_CONST_TIME_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign aeqb = aeqb_q;
  assign agtb = agtb_q;
  assign altb = altb_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp (W=8). Expected flags and latency
// come from a reference model and are queued when a compare is launched.
module tb_serial_mag_cmp;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy, done, aeqb, agtb, altb;

  typedef struct {
    logic [2:0] flags;  // {aeqb, agtb, altb}
    int         lat;    // edges from accepting start to done
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .aeqb  (aeqb),
    .agtb  (agtb),
    .altb  (altb)
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.flags = (x == y) ? 3'b100 : (x > y) ? 3'b010 : 3'b001;
    e.lat   = W/2;
`ifndef SERIAL_MAG_CMP_CONST_TIME_EN
    for (int k = 1; k <= int'(W/2); k++) begin
      if (x[W-2*k +: 2] != y[W-2*k +: 2]) begin
        e.lat = k;
        break;
      end
    end
`endif
    return e;
  endfunction

  // Drive a one-cycle start pulse; returns 1 ns after the accepting edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb_q.push_back(model(x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    exp_t e;
    int   lat;
    tests++; if ({busy, done, aeqb, agtb, altb} !== 5'b0) begin fails++; $display("FAIL reset_state: got %b want 00000", {busy, done, aeqb, agtb, altb}); end
    @(negedge clk); reset = 1'b0;
    launch(8'h55, 8'h55);
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy_before: got %b want 1", busy); end
    reset = 1'b1; #1;
    tests++; if ({busy, done, aeqb, agtb, altb} !== 5'b0) begin fails++; $display("FAIL reset_midcmp: got %b want 00000", {busy, done, aeqb, agtb, altb}); end
    void'(sb_q.pop_front());
    @(negedge clk); reset = 1'b0;
    launch(8'h55, 8'h55);
    wait_done(lat);
    e = sb_q.pop_front();
    tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL reset_after_flags: got %b want %b", {aeqb, agtb, altb}, e.flags); end
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL reset_after_lat: got %0d want %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_equal;
    exp_t e;
    int   lat;
    launch(8'hA5, 8'hA5);
    wait_done(lat);
    e = sb_q.pop_front();
    tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL equal_flags: got %b want %b", {aeqb, agtb, altb}, e.flags); end
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL equal_lat: got %0d want %0d", lat, e.lat); end
    @(posedge clk); #1;
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL equal_busy_drop: got busy,done=%b want 00", {busy, done}); end
    // Flags persist while idle even as the operand inputs move.
    a = 8'h00; b = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL equal_hold: got %b want %b", {aeqb, agtb, altb}, e.flags); end
  endtask

  task automatic test_slice_diff;
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    exp_t e;
    int   lat;
    xs = '{8'hC0, 8'h12, 8'h80, 8'h3C};
    ys = '{8'h40, 8'h13, 8'h7F, 8'h2C};
    for (int i = 0; i < 4; i++) begin
      launch(xs[i], ys[i]);
      wait_done(lat);
      e = sb_q.pop_front();
      tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL diff_flags[%0d]: got %b want %b", i, {aeqb, agtb, altb}, e.flags); end
      tests++; if (lat !== e.lat) begin fails++; $display("FAIL diff_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_while_busy;
    exp_t e;
    int   lat;
    launch(8'h12, 8'h13);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    if (lat > 0) lat = lat + 1;
    e = sb_q.pop_front();
    tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL busy_start_flags: got %b want %b", {aeqb, agtb, altb}, e.flags); end
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL busy_start_lat: got %0d want %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   lat;
    launch(8'h33, 8'h33);
    @(negedge clk); a = 8'hFF;
    wait_done(lat);
    e = sb_q.pop_front();
    tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL opchange_flags: got %b want %b", {aeqb, agtb, altb}, e.flags); end
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL opchange_lat: got %0d want %0d", lat, e.lat); end
    // Hold start from the DONE cycle; accept must happen on the first IDLE edge.
    a = 8'h3C; b = 8'h2C; start = 1'b1;
    sb_q.push_back(model(8'h3C, 8'h2C));
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    start = 1'b0;
    wait_done(lat);
    e = sb_q.pop_front();
    tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL b2b_flags: got %b want %b", {aeqb, agtb, altb}, e.flags); end
    tests++; if (lat !== e.lat) begin fails++; $display("FAIL b2b_lat: got %0d want %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    exp_t e;
    int   lat;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom);
      case (i % 4)
        0:       y = x;
        1:       y = x ^ W'(1 << $urandom_range(0, W-1));
        default: y = W'($urandom);
      endcase
      launch(x, y);
      wait_done(lat);
      e = sb_q.pop_front();
      tests++; if ({aeqb, agtb, altb} !== e.flags) begin fails++; $display("FAIL rand_flags a=%h b=%h: got %b want %b", x, y, {aeqb, agtb, altb}, e.flags); end
      tests++; if (lat !== e.lat) begin fails++; $display("FAIL rand_lat a=%h b=%h: got %0d want %0d", x, y, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_equal();
    test_slice_diff();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
